// File: rtl/ic_tester_pkg.sv
// Shared definitions for the logic-IC tester: gate-type encodings, sequencer states, vector count.
// Optional build macro used by the sequencer: EARLY_ABORT_EN.
package ic_tester_pkg;

    localparam logic [2:0] GT_AND  = 3'd0;
    localparam logic [2:0] GT_OR   = 3'd1;
    localparam logic [2:0] GT_NAND = 3'd2;
    localparam logic [2:0] GT_NOR  = 3'd3;
    localparam logic [2:0] GT_XOR  = 3'd4;
    localparam logic [2:0] GT_XNOR = 3'd5;

    localparam int NUM_VECTORS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_NEXT,
        S_DONE
    } state_t;

    function automatic logic type_valid(input logic [2:0] t);
        return t <= GT_XNOR;
    endfunction

endpackage

// File: rtl/gate_model.sv
// Combinational reference model of one 2-input gate; invalid types yield 0.
module gate_model
    import ic_tester_pkg::*;
(
    input  logic [2:0] gate_type,
    input  logic       a,
    input  logic       b,
    output logic       y
);

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        y = 1'b0;
        case (gate_type)
            GT_AND:  y = a & b;
            GT_OR:   y = a | b;
            GT_NAND: y = ~(a & b);
            GT_NOR:  y = ~(a | b);
            GT_XOR:  y = a ^ b;
            GT_XNOR: y = ~(a ^ b);
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/ic_test_sequencer.sv
// Walks each gate channel through the 2-bit truth table and grades it against gate_model.
// Define EARLY_ABORT_EN to stop testing a gate at its first mismatching vector.
module ic_test_sequencer
    import ic_tester_pkg::*;
#(
    parameter int NUM_GATES     = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 icg,
    input  logic [2:0]           gate_type,
    input  logic [NUM_GATES-1:0] dut_y,
    output logic [NUM_GATES-1:0] stim_a,
    output logic [NUM_GATES-1:0] stim_b,
    output logic                 busy,
    output logic                 done,
    output logic                 abort,
    output logic [NUM_GATES-1:0] pass,
    output logic [NUM_GATES-1:0] fail,
    output logic [2*CNT_W-1:0]   COUNT
);

    localparam int GATE_W = 4;
    localparam int SC_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SC_W-1:0]   SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [GATE_W-1:0] LAST_GATE   = GATE_W'(NUM_GATES - 1);
    localparam logic [1:0]        LAST_VEC    = 2'(NUM_VECTORS - 1);

    state_t               state, next_state;
    logic [GATE_W-1:0]    gate;
    logic [1:0]           vec;
    logic [SC_W-1:0]      settle_cnt;
    logic                 gate_err;
    logic [2:0]           type_q;
    logic [CNT_W-1:0]     pass_cnt, fail_cnt;
    logic                 abort_q;

    logic [NUM_GATES-1:0] sel;
    logic                 drive;
    logic                 expected;
    logic                 mismatch;
    logic                 lost_icg;

    gate_model u_model (
        .gate_type (type_q),
        .a         (vec[1]),
        .b         (vec[0]),
        .y         (expected)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            sel[i] = (gate == GATE_W'(i));
        end
    end

    // Stimulus drops the instant icg falls, without waiting for the state to change.
    assign drive    = icg && (state == S_APPLY || state == S_SETTLE || state == S_SAMPLE);
    assign stim_a   = (drive && vec[1]) ? sel : '0;
    assign stim_b   = (drive && vec[0]) ? sel : '0;
    assign mismatch = (|(dut_y & sel)) != expected;
    assign lost_icg = (state != S_IDLE) && !icg;

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE) && icg;
    assign abort = abort_q;
    assign COUNT = {fail_cnt, pass_cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start && icg && type_valid(gate_type)) next_state = S_APPLY;
            S_APPLY:  next_state = S_SETTLE;
            S_SETTLE: if (settle_cnt == '0) next_state = S_SAMPLE;
            S_SAMPLE: begin
`ifdef EARLY_ABORT_EN
                if (mismatch)             next_state = S_NEXT;
                else if (vec != LAST_VEC) next_state = S_APPLY;
                else                      next_state = S_NEXT;
`else
                if (vec != LAST_VEC) next_state = S_APPLY;
                else                 next_state = S_NEXT;
`endif
            end
            S_NEXT:   next_state = (gate == LAST_GATE) ? S_DONE : S_APPLY;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (lost_icg) next_state = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate       <= '0;
            vec        <= '0;
            settle_cnt <= '0;
            gate_err   <= 1'b0;
            type_q     <= GT_AND;
            pass       <= '0;
            fail       <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            abort_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, matching the flops.
            abort_q <= 1'b0;
            if (lost_icg) begin
                abort_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (next_state == S_APPLY) begin
                            gate     <= '0;
                            vec      <= '0;
                            gate_err <= 1'b0;
                            type_q   <= gate_type;
                            pass     <= '0;
                            fail     <= '0;
                            pass_cnt <= '0;
                            fail_cnt <= '0;
                        end
                    end
                    S_APPLY:  settle_cnt <= SETTLE_LOAD;
                    S_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                    S_SAMPLE: begin
                        gate_err <= gate_err | mismatch;
                        if (next_state == S_APPLY) vec <= vec + 1'b1;
                    end
                    S_NEXT: begin
                        if (gate_err) begin
                            fail     <= fail | sel;
                            fail_cnt <= fail_cnt + 1'b1;
                        end else begin
                            pass     <= pass | sel;
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                        gate_err <= 1'b0;
                        vec      <= '0;
                        if (gate != LAST_GATE) gate <= gate + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Directed bench for ic_test_sequencer: emulated DUT IC with fault injection, hand-computed results.
module tb_ic_test_sequencer;

    localparam int NG = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          icg;
    logic [2:0]    gate_type;
    logic [NG-1:0] dut_y;
    logic [NG-1:0] stim_a, stim_b;
    logic          busy, done, abort;
    logic [NG-1:0] pass, fail;
    logic [7:0]    COUNT;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc;
    int            n;

    logic [2:0]    ic_type;
    logic [NG-1:0] stuck1;
    logic          tie0;

    ic_test_sequencer #(.NUM_GATES(NG), .SETTLE_CYCLES(4), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .icg       (icg),
        .gate_type (gate_type),
        .dut_y     (dut_y),
        .stim_a    (stim_a),
        .stim_b    (stim_b),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .pass      (pass),
        .fail      (fail),
        .COUNT     (COUNT)
    );

    always #5 clk = ~clk;

    function automatic logic ic_gate(input logic [2:0] t, input logic a, input logic b);
        case (t)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    // Emulated IC under test, with stuck-at-1 channels or all outputs tied low.
    always_comb begin
        dut_y = '0;
        for (int i = 0; i < NG; i++) begin
            if (tie0)           dut_y[i] = 1'b0;
            else if (stuck1[i]) dut_y[i] = 1'b1;
            else                dut_y[i] = ic_gate(ic_type, stim_a[i], stim_b[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_start(input logic [2:0] t);
        gate_type = t;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done();
        while (!done && cyc < 400) step();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        icg       = 1'b1;
        gate_type = 3'd0;
        ic_type   = 3'd0;
        stuck1    = '0;
        tie0      = 1'b0;
        cyc       = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_flags", 32'({done, abort}), 32'h0);
        check("rst_pf",    32'({pass, fail}), 32'h0);
        check("rst_count", 32'(COUNT), 32'h0);
        check("rst_stim",  32'({stim_a, stim_b}), 32'h0);
        reset = 1'b0;
        step();

        // Good AND IC, with a stray start pulse mid-run.
        pulse_start(3'd0);
        check("and_c1_busy", 32'(busy), 32'h1);
        check("and_c1_stim", 32'({stim_a, stim_b}), 32'h0);
        while (cyc < 8) step();
        check("and_c8_stim_a", 32'(stim_a), 32'h00);
        check("and_c8_stim_b", 32'(stim_b), 32'h01);
        while (cyc < 10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < 44) step();
        check("and_c44_stim_a", 32'(stim_a), 32'h02);
        check("and_c44_stim_b", 32'(stim_b), 32'h02);
        wait_done();
        check("and_done_cycle", 32'(cyc), 32'd151);
        check("and_pass",  32'(pass), 32'h3F);
        check("and_fail",  32'(fail), 32'h00);
        check("and_count", 32'(COUNT), 32'h06);
        check("and_abort", 32'(abort), 32'h0);
        step();
        check("and_done_pulse", 32'({done, busy}), 32'h0);

        // NAND IC with channel 2 stuck at 1: only the 11 vector exposes it.
        ic_type = 3'd2;
        stuck1  = 6'b000100;
        pulse_start(3'd2);
        wait_done();
        check("nand_done_cycle", 32'(cyc), 32'd151);
        check("nand_fail",  32'(fail), 32'h04);
        check("nand_pass",  32'(pass), 32'h3B);
        check("nand_count", 32'(COUNT), 32'h15);
        step();

        // XOR IC with every output tied low.
        ic_type = 3'd4;
        stuck1  = '0;
        tie0    = 1'b1;
        pulse_start(3'd4);
        wait_done();
        check("xor_done_seen", 32'(done), 32'h1);
        check("xor_fail",  32'(fail), 32'h3F);
        check("xor_pass",  32'(pass), 32'h00);
        check("xor_count", 32'(COUNT), 32'h60);
        step();

        // Good AND IC, icg lost after gate 1 is graded (gate 1 finishes at cycle 50).
        ic_type = 3'd0;
        tie0    = 1'b0;
        pulse_start(3'd0);
        while (cyc < 60) step();
        check("abort_pre_busy", 32'(busy), 32'h1);
        icg = 1'b0;
        #1;
        check("abort_stim_now", 32'({stim_a, stim_b}), 32'h0);
        step();
        check("abort_pulse", 32'(abort), 32'h1);
        check("abort_busy",  32'({busy, done}), 32'h0);
        check("abort_pass",  32'(pass), 32'h03);
        check("abort_fail",  32'(fail), 32'h00);
        check("abort_count", 32'(COUNT), 32'h02);
        step();
        check("abort_one_cycle", 32'(abort), 32'h0);
        icg = 1'b1;
        step();

        // Rejected starts: invalid type, then valid type with icg low.
        gate_type = 3'd6;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bad_type_idle", 32'({busy, done, abort}), 32'h0);
        end
        check("bad_type_hold", 32'(COUNT), 32'h02);
        icg       = 1'b0;
        gate_type = 3'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_icg_idle", 32'({busy, done, abort}), 32'h0);
        end
        icg = 1'b1;
        step();

        // Reset asserted while gate 1 is settling.
        pulse_start(3'd0);
        while (cyc < 30) step();
        check("rst_mid_pre_count", 32'(COUNT), 32'h01);
        check("rst_mid_pre_stim",  32'(stim_a | stim_b), 32'h00);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy",  32'({busy, done, abort}), 32'h0);
        check("rst_mid_pf",    32'({pass, fail}), 32'h0);
        check("rst_mid_count", 32'(COUNT), 32'h0);
        check("rst_mid_stim",  32'({stim_a, stim_b}), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("rst_mid_after", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
